fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 W_pc  out  32  address of next instruction to request; feeds NextPC W_pc.
REQ-004 W_pc_sel  out  2  NextPC select: ADD4=0, BRANCH=1, J_IMME=2, J_R=3.
REQ-005 W_next_pc  in  32  NextPC result for current W_pc_sel.
REQ-006 W_redirect  in  1  ID stage holds a taken branch/jump this cycle.
REQ-007 W_redirect_sel  in  2  ID-decoded select code; valid when W_redirect=1; never ADD4.
REQ-008 W_flush / W_flush_pc  in  1/32  exception redirect and its target.
REQ-009 W_inst_req / W_inst_addr  out  1/32  instruction memory request and address.
REQ-010 W_inst_addr_ok / W_inst_data_ok / W_inst_rdata  in  1/1/32  address accept, data return, data.
REQ-011 W_id_stall  in  1  ID cannot accept an instruction this cycle.
REQ-012 W_if_valid / W_if_inst / W_if_pc  out  1/32/32  instruction presented to ID.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, OUT, DROP.
REQ-014 IDLE SHALL go to REQ after one cycle.
REQ-015 REQ SHALL drive W_inst_req=1 and W_inst_addr=W_pc, and hold both stable until W_inst_addr_ok.
REQ-016 On W_inst_addr_ok in REQ, the FSM SHALL go to WAIT, and the requested address SHALL be captured as if_pc.
REQ-017 WAIT SHALL capture W_inst_rdata on W_inst_data_ok, then go to OUT. Data_ok in the same cycle as addr_ok SHALL go directly to OUT.
REQ-018 OUT SHALL assert W_if_valid. When W_id_stall=0, OUT SHALL go to REQ. Otherwise OUT SHALL hold with W_if_inst/W_if_pc unchanged.
REQ-019 At most one request SHALL be outstanding. A new request SHALL NOT start until the presented instruction is consumed.
REQ-020 W_pc_sel SHALL equal W_redirect_sel when W_redirect=1, else ADD4.
REQ-021 On addr_ok with no redirect and no pending target, the PC update SHALL be W_pc <= W_next_pc (pc+4).
REQ-022 Redirect outside REQ: W_pc <= W_next_pc (the target). The in-flight or held instruction is the delay slot and SHALL NOT be squashed.
REQ-023 Redirect in REQ without addr_ok: the target SHALL be latched in pend_pc and pend_valid set. The current request (delay slot) SHALL continue unchanged.
REQ-024 On addr_ok with pend_valid=1: W_pc <= pend_pc, then pend_valid cleared.
REQ-025 Redirect in REQ with addr_ok in the same cycle: W_pc <= W_next_pc (target), and the +4 SHALL be suppressed.
REQ-026 A redirect repeated while ID stalls SHALL be idempotent: same target, with no second advance.
REQ-027 W_flush SHALL have highest priority. On W_flush: W_pc <= W_flush_pc, pend_valid cleared, W_if_valid deasserted next cycle.
REQ-028 Flush in WAIT, or in REQ with addr_ok, SHALL go to DROP. DROP SHALL discard the next W_inst_data_ok and then go to REQ.
REQ-029 Flush in REQ without addr_ok, or in OUT or IDLE, SHALL go to REQ next cycle. A pending request SHALL be withdrawn only if addr_ok=0.
REQ-030 Flush and redirect in the same cycle: flush wins and the redirect is ignored.
REQ-031 All address arithmetic is 32-bit modulo. Wrap at 0xFFFFFFFC SHALL be unguarded.

Reset
REQ-032 On rst: state=IDLE, W_pc=0xBFC00000, pend_valid=0, pend_pc=0, W_inst_req=0, W_if_valid=0, W_if_inst=0, W_if_pc=0.
REQ-033 Reset SHALL override flush and redirect. Reset asserted mid-transaction SHALL abandon it, and a late data_ok SHALL be ignored until the first REQ.

Structure
REQ-034 PC_SEL_* codes, the reset vector and the state encodings SHALL live in the shared defines file.
REQ-035 NextPC SHALL be instantiated outside this block. No sub-module is required.

Verification
REQ-036 Reset release, zero-wait memory (addr_ok and data_ok same cycle): W_inst_addr = BFC00000, BFC00004, BFC00008 on consecutive REQ phases, and W_if_pc matches each.
REQ-037 Branch in ID with the delay slot in OUT, target 0xBFC00100: the delay slot at BFC00008 SHALL be presented, and the next request SHALL be 0xBFC00100.
REQ-038 Redirect during REQ with addr_ok withheld 3 cycles: request address SHALL be unchanged during the wait, and the following request SHALL be the latched target.
REQ-039 Flush (0xBFC00380) while in WAIT: the returned data SHALL be dropped with no W_if_valid, and the next request SHALL be 0xBFC00380.
REQ-040 W_id_stall held 4 cycles in OUT: W_if_inst/W_if_pc SHALL be stable, with no W_inst_req, and the redirect repeated 4 times SHALL yield a single target.
REQ-041 rst asserted in WAIT with data_ok arriving next cycle: the state SHALL be IDLE, W_if_valid=0, and the first request SHALL be BFC00000.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared definitions for the instruction fetch controller.
//   NextPC select codes, reset vector, FSM state encoding, IF->ID payload.
package fetch_ctrl_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned SEL_W = 2;

   // NextPC select codes
   localparam logic [SEL_W-1:0] PC_SEL_ADD4    = 2'd0;
   localparam logic [SEL_W-1:0] PC_SEL_BRANCH  = 2'd1;
   localparam logic [SEL_W-1:0] PC_SEL_J_IMME  = 2'd2;
   localparam logic [SEL_W-1:0] PC_SEL_J_R     = 2'd3;

   localparam logic [XLEN-1:0]  RESET_VECTOR   = 32'hBFC0_0000;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_WAIT = 3'd2,
      ST_OUT  = 3'd3,
      ST_DROP = 3'd4
   } fetch_state_e;

   // Instruction presented to ID
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } if_pkt_t;

   // NextPC select: taken redirect code from ID, otherwise sequential
   function automatic logic [SEL_W-1:0] pc_sel_f(input logic             redirect,
                                                 input logic [SEL_W-1:0] sel);
      return redirect ? sel : PC_SEL_ADD4;
   endfunction

endpackage

// File: rtl/fetch_ctrl_pc.sv
// fetch_ctrl_pc: fetch PC register plus the pending-redirect latch.
//   clk, rst         : clock, synchronous active-high reset
//   i_flush/_pc      : exception redirect (highest priority) and target
//   i_redirect       : ID holds a taken branch/jump; i_next_pc is its target
//   i_next_pc        : NextPC result (pc+4 or redirect target)
//   i_in_req         : fetch FSM is in REQ (request on the bus)
//   i_addr_ok        : memory accepted the current request address
//   o_pc             : address of the next instruction to request
module fetch_ctrl_pc
   import fetch_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_flush_pc,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_next_pc,
   input  logic            i_in_req,
   input  logic            i_addr_ok,
   output logic [XLEN-1:0] o_pc
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pend_pc;
   logic            r_pend_valid;

   logic [XLEN-1:0] w_pc_nxt;
   logic [XLEN-1:0] w_pend_pc_nxt;
   logic            w_pend_valid_nxt;

   // PC / pending-target update priority: flush > accept > hold-in-REQ > redirect
   always_comb begin
      w_pc_nxt         = r_pc;
      w_pend_pc_nxt    = r_pend_pc;
      w_pend_valid_nxt = r_pend_valid;

      if (i_flush) begin
         w_pc_nxt         = i_flush_pc;
         w_pend_valid_nxt = 1'b0;
      end else if (i_in_req && i_addr_ok) begin
         // Request accepted: a same-cycle redirect replaces the +4,
         // otherwise a latched target wins over sequential flow.
         if (i_redirect) begin
            w_pc_nxt = i_next_pc;
         end else if (r_pend_valid) begin
            w_pc_nxt = r_pend_pc;
         end else begin
            w_pc_nxt = i_next_pc;
         end
         w_pend_valid_nxt = 1'b0;
      end else if (i_in_req) begin
         // Address must stay stable on the bus, so park the target
         if (i_redirect) begin
            w_pend_pc_nxt    = i_next_pc;
            w_pend_valid_nxt = 1'b1;
         end
      end else if (i_redirect) begin
         // Outside REQ the in-flight/held instruction is the delay slot
         w_pc_nxt = i_next_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= RESET_VECTOR;
         r_pend_pc    <= '0;
         r_pend_valid <= 1'b0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_pend_pc    <= w_pend_pc_nxt;
         r_pend_valid <= w_pend_valid_nxt;
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch controller.
//   clk, rst                    : clock, synchronous active-high reset
//   W_pc / W_pc_sel             : PC and select code toward external NextPC
//   W_next_pc                   : NextPC result for W_pc_sel
//   W_redirect / W_redirect_sel : taken branch/jump in ID and its select code
//   W_flush / W_flush_pc        : exception redirect and target
//   W_inst_req / W_inst_addr    : instruction memory request
//   W_inst_addr_ok/_data_ok/_rdata : memory handshake and returned data
//   W_id_stall                  : ID cannot accept this cycle
//   W_if_valid/_inst/_pc        : instruction presented to ID
module fetch_ctrl
   import fetch_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   output logic [XLEN-1:0]  W_pc,
   output logic [SEL_W-1:0] W_pc_sel,
   input  logic [XLEN-1:0]  W_next_pc,
   input  logic             W_redirect,
   input  logic [SEL_W-1:0] W_redirect_sel,
   input  logic             W_flush,
   input  logic [XLEN-1:0]  W_flush_pc,
   output logic             W_inst_req,
   output logic [XLEN-1:0]  W_inst_addr,
   input  logic             W_inst_addr_ok,
   input  logic             W_inst_data_ok,
   input  logic [XLEN-1:0]  W_inst_rdata,
   input  logic             W_id_stall,
   output logic             W_if_valid,
   output logic [XLEN-1:0]  W_if_inst,
   output logic [XLEN-1:0]  W_if_pc
);

   fetch_state_e r_state;
   fetch_state_e w_state_nxt;
   logic         r_inst_req;
   logic         r_if_valid;
   if_pkt_t      r_if;

   logic         w_in_req;
   logic         w_cap_pc;
   logic         w_cap_inst;

   assign w_in_req = (r_state == ST_REQ);

   // PC and pending-redirect bookkeeping
   fetch_ctrl_pc u_pc (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (W_flush),
      .i_flush_pc (W_flush_pc),
      .i_redirect (W_redirect),
      .i_next_pc  (W_next_pc),
      .i_in_req   (w_in_req),
      .i_addr_ok  (W_inst_addr_ok),
      .o_pc       (W_pc)
   );

   // Next-state and capture strobes
   always_comb begin
      w_state_nxt = r_state;
      w_cap_pc    = 1'b0;
      w_cap_inst  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (W_flush) begin
               // Accepted-but-unreturned data must be drained; otherwise
               // the request is simply withdrawn and reissued.
               w_state_nxt = (W_inst_addr_ok && !W_inst_data_ok) ? ST_DROP : ST_REQ;
            end else if (W_inst_addr_ok) begin
               w_cap_pc = 1'b1;
               if (W_inst_data_ok) begin
                  w_cap_inst  = 1'b1;
                  w_state_nxt = ST_OUT;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (W_flush) begin
               w_state_nxt = W_inst_data_ok ? ST_REQ : ST_DROP;
            end else if (W_inst_data_ok) begin
               w_cap_inst  = 1'b1;
               w_state_nxt = ST_OUT;
            end
         end
         ST_OUT: begin
            if (W_flush || !W_id_stall) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_DROP: begin
            if (W_inst_data_ok) begin
               w_state_nxt = ST_REQ;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register; request/valid are decoded from the next state so they
   // leave the block straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_inst_req <= 1'b0;
         r_if_valid <= 1'b0;
         r_if       <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_inst_req <= (w_state_nxt == ST_REQ);
         r_if_valid <= (w_state_nxt == ST_OUT);
         if (w_cap_pc) begin
            r_if.pc <= W_pc;
         end
         if (w_cap_inst) begin
            r_if.inst <= W_inst_rdata;
         end
      end
   end

   assign W_pc_sel    = pc_sel_f(W_redirect, W_redirect_sel);
   assign W_inst_req  = r_inst_req;
   assign W_inst_addr = W_pc;
   assign W_if_valid  = r_if_valid;
   assign W_if_inst   = r_if.inst;
   assign W_if_pc     = r_if.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
//   Drives memory handshakes and ID redirects step by step; NextPC is
//   modelled as pc+4 for ADD4 and a bench-chosen target otherwise.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] W_pc;
   logic [1:0]  W_pc_sel;
   logic [31:0] W_next_pc;
   logic        W_redirect;
   logic [1:0]  W_redirect_sel;
   logic        W_flush;
   logic [31:0] W_flush_pc;
   logic        W_inst_req;
   logic [31:0] W_inst_addr;
   logic        W_inst_addr_ok;
   logic        W_inst_data_ok;
   logic [31:0] W_inst_rdata;
   logic        W_id_stall;
   logic        W_if_valid;
   logic [31:0] W_if_inst;
   logic [31:0] W_if_pc;

   logic [31:0] tgt;
   int          checks;
   int          failures;

   // External NextPC model
   assign W_next_pc = (W_pc_sel == 2'd0) ? W_pc + 32'd4 : tgt;

   fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .W_pc           (W_pc),
      .W_pc_sel       (W_pc_sel),
      .W_next_pc      (W_next_pc),
      .W_redirect     (W_redirect),
      .W_redirect_sel (W_redirect_sel),
      .W_flush        (W_flush),
      .W_flush_pc     (W_flush_pc),
      .W_inst_req     (W_inst_req),
      .W_inst_addr    (W_inst_addr),
      .W_inst_addr_ok (W_inst_addr_ok),
      .W_inst_data_ok (W_inst_data_ok),
      .W_inst_rdata   (W_inst_rdata),
      .W_id_stall     (W_id_stall),
      .W_if_valid     (W_if_valid),
      .W_if_inst      (W_if_inst),
      .W_if_pc        (W_if_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mem(input logic aok, input logic dok, input logic [31:0] data);
      W_inst_addr_ok = aok;
      W_inst_data_ok = dok;
      W_inst_rdata   = data;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; W_redirect = 1'b0; W_redirect_sel = 2'd0; W_flush = 1'b0;
      W_flush_pc = 32'h0; W_id_stall = 1'b0; tgt = 32'h0;
      mem(1'b0, 1'b0, 32'h0);

      // Reset state
      step(); step();
      chk("rst_pc",       W_pc,       32'hBFC00000);
      chk("rst_req",      W_inst_req, 32'd0);
      chk("rst_valid",    W_if_valid, 32'd0);
      chk("rst_if_inst",  W_if_inst,  32'd0);
      chk("rst_if_pc",    W_if_pc,    32'd0);
      rst = 1'b0;

      // Zero-wait sequential fetch
      step();
      chk("zw0_req",  W_inst_req,  32'd1);
      chk("zw0_addr", W_inst_addr, 32'hBFC00000);
      chk("sel_add4", W_pc_sel,    32'd0);
      mem(1'b1, 1'b1, ~32'hBFC00000);
      step();
      chk("zw0_valid", W_if_valid, 32'd1);
      chk("zw0_ifpc",  W_if_pc,    32'hBFC00000);
      chk("zw0_inst",  W_if_inst,  ~32'hBFC00000);
      chk("zw0_noreq", W_inst_req, 32'd0);
      mem(1'b0, 1'b0, 32'h0);
      step();
      chk("zw1_addr", W_inst_addr, 32'hBFC00004);
      mem(1'b1, 1'b1, ~32'hBFC00004);
      step();
      chk("zw1_ifpc", W_if_pc, 32'hBFC00004);
      mem(1'b0, 1'b0, 32'h0);
      step();
      chk("zw2_addr", W_inst_addr, 32'hBFC00008);
      mem(1'b1, 1'b1, ~32'hBFC00008);
      step();
      chk("zw2_valid", W_if_valid, 32'd1);
      chk("zw2_ifpc",  W_if_pc,    32'hBFC00008);
      mem(1'b0, 1'b0, 32'h0);

      // Branch in ID while delay slot is in OUT
      W_redirect = 1'b1; W_redirect_sel = 2'd1; tgt = 32'hBFC00100;
      step();
      W_redirect = 1'b0;
      chk("br_req",  W_inst_req,  32'd1);
      chk("br_addr", W_inst_addr, 32'hBFC00100);

      // Redirect during REQ with addr_ok withheld 3 cycles
      W_redirect = 1'b1; W_redirect_sel = 2'd2; tgt = 32'hBFC00200;
      #1;
      chk("sel_jimm", W_pc_sel, 32'd2);
      step();
      W_redirect = 1'b0;
      chk("pend_addr0", W_inst_addr, 32'hBFC00100);
      step();
      chk("pend_addr1", W_inst_addr, 32'hBFC00100);
      step();
      chk("pend_addr2", W_inst_addr, 32'hBFC00100);
      chk("pend_req2",  W_inst_req,  32'd1);
      mem(1'b1, 1'b0, 32'h0);
      step();
      chk("pend_wait_req",   W_inst_req, 32'd0);
      chk("pend_wait_valid", W_if_valid, 32'd0);
      chk("pend_pc",         W_pc,       32'hBFC00200);
      mem(1'b0, 1'b1, ~32'hBFC00100);
      step();
      chk("pend_valid", W_if_valid, 32'd1);
      chk("pend_ifpc",  W_if_pc,    32'hBFC00100);
      chk("pend_inst",  W_if_inst,  ~32'hBFC00100);
      mem(1'b0, 1'b0, 32'h0);
      step();
      chk("pend_next_addr", W_inst_addr, 32'hBFC00200);

      // Flush while in WAIT
      mem(1'b1, 1'b0, 32'h0);
      step();
      W_flush = 1'b1; W_flush_pc = 32'hBFC00380;
      mem(1'b0, 1'b0, 32'h0);
      step();
      W_flush = 1'b0;
      chk("fl_pc",    W_pc,       32'hBFC00380);
      chk("fl_valid", W_if_valid, 32'd0);
      chk("fl_req",   W_inst_req, 32'd0);
      mem(1'b0, 1'b1, 32'hDEADBEEF);
      step();
      chk("fl_drop_valid", W_if_valid,  32'd0);
      chk("fl_drop_inst",  W_if_inst,   ~32'hBFC00100);
      chk("fl_req2",       W_inst_req,  32'd1);
      chk("fl_addr",       W_inst_addr, 32'hBFC00380);

      // ID stall 4 cycles with the redirect repeated each cycle
      mem(1'b1, 1'b1, ~32'hBFC00380);
      step();
      mem(1'b0, 1'b0, 32'h0);
      W_id_stall = 1'b1; W_redirect = 1'b1; W_redirect_sel = 2'd3; tgt = 32'hBFC00500;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("st_valid", W_if_valid, 32'd1);
         chk("st_ifpc",  W_if_pc,    32'hBFC00380);
         chk("st_inst",  W_if_inst,  ~32'hBFC00380);
         chk("st_noreq", W_inst_req, 32'd0);
         chk("st_pc",    W_pc,       32'hBFC00500);
      end
      W_id_stall = 1'b0; W_redirect = 1'b0;
      step();
      chk("st_next_addr", W_inst_addr, 32'hBFC00500);

      // Reset in WAIT with a late data_ok
      mem(1'b1, 1'b0, 32'h0);
      step();
      rst = 1'b1;
      mem(1'b0, 1'b0, 32'h0);
      step();
      chk("mrst_valid", W_if_valid, 32'd0);
      chk("mrst_req",   W_inst_req, 32'd0);
      chk("mrst_pc",    W_pc,       32'hBFC00000);
      rst = 1'b0;
      mem(1'b0, 1'b1, 32'h12345678);
      step();
      chk("mrst_req2",  W_inst_req,  32'd1);
      chk("mrst_addr",  W_inst_addr, 32'hBFC00000);
      chk("mrst_valid2", W_if_valid, 32'd0);
      chk("mrst_inst",  W_if_inst,   32'd0);
      mem(1'b1, 1'b1, ~32'hBFC00000);
      step();
      chk("mrst_ifpc", W_if_pc, 32'hBFC00000);
      mem(1'b0, 1'b0, 32'h0);

      // Flush in OUT to the top of the address space, then wrap
      W_flush = 1'b1; W_flush_pc = 32'hFFFFFFFC; W_id_stall = 1'b1;
      step();
      W_flush = 1'b0; W_id_stall = 1'b0;
      chk("wr_valid", W_if_valid,  32'd0);
      chk("wr_addr",  W_inst_addr, 32'hFFFFFFFC);
      mem(1'b1, 1'b1, 32'h00000003);
      step();
      chk("wr_pc",   W_pc,    32'h00000000);
      chk("wr_ifpc", W_if_pc, 32'hFFFFFFFC);
      mem(1'b0, 1'b0, 32'h0);
      step();
      chk("wr_addr0", W_inst_addr, 32'h00000000);

      // Pending redirect then flush+redirect: flush wins, pending dropped
      W_redirect = 1'b1; W_redirect_sel = 2'd1; tgt = 32'hBFC00700;
      step();
      chk("fr_hold", W_inst_addr, 32'h00000000);
      W_flush = 1'b1; W_flush_pc = 32'hBFC00380; tgt = 32'hBFC00800;
      step();
      W_flush = 1'b0; W_redirect = 1'b0;
      chk("fr_addr", W_inst_addr, 32'hBFC00380);
      chk("fr_req",  W_inst_req,  32'd1);
      mem(1'b1, 1'b1, ~32'hBFC00380);
      step();
      chk("fr_pc", W_pc, 32'hBFC00384);
      mem(1'b0, 1'b0, 32'h0);

      // Redirect in REQ with addr_ok the same cycle: +4 suppressed
      step();
      chk("ra_addr", W_inst_addr, 32'hBFC00384);
      mem(1'b1, 1'b1, ~32'hBFC00384);
      W_redirect = 1'b1; W_redirect_sel = 2'd1; tgt = 32'hBFC00900;
      step();
      W_redirect = 1'b0;
      mem(1'b0, 1'b0, 32'h0);
      chk("ra_pc",   W_pc,    32'hBFC00900);
      chk("ra_ifpc", W_if_pc, 32'hBFC00384);
      step();
      chk("ra_next_addr", W_inst_addr, 32'hBFC00900);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
